// File: rtl/lfsr_pkg.sv
// lfsr_pkg: state encoding for the LFSR sequence checker, default LFSR constants
// and the shared next-state function used by both generator and checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam int                    LFSR_WIDTH = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 4'b1100;
  localparam int                    LFSR_MAX_W = 32;

  // Callers zero-extend to LFSR_MAX_W and truncate the result back to their width;
  // the low bits then equal {cur[W-2:0], ^(cur & taps)} for any W up to LFSR_MAX_W.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] cur,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {cur[LFSR_MAX_W-2:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_fsm.sv
// lfsr_seq_checker_fsm: SEARCH/VERIFY/LOCKED state machine with match and miss counters.
// With LFSR_CHK_PERIOD_EN defined it also exports the combinational unlock strobe.
module lfsr_seq_checker_fsm
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT    = 3,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_dinZero,
  input  logic        i_dinMatch,
  output lfsr_state_e o_state,
  output logic        o_locked
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic        o_unlock
`endif
);

  localparam logic [3:0] LOCK_TARGET   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TARGET = 4'(UNLOCK_ERRS);

  lfsr_state_e r_state;
  logic [3:0]  r_match;
  logic [3:0]  r_miss;
  logic        r_locked;
  logic [3:0]  w_matchInc;
  logic [3:0]  w_missInc;

  assign w_matchInc = r_match + 4'd1;
  assign w_missInc  = r_miss + 4'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= SEARCH;
      r_match  <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        SEARCH: begin
          if (!i_dinZero) begin
            r_match <= '0;
            r_state <= VERIFY;
          end
        end
        VERIFY: begin
          if (i_dinMatch) begin
            r_match <= w_matchInc;
            if (w_matchInc == LOCK_TARGET) begin
              r_state  <= LOCKED;
              r_miss   <= '0;
              r_locked <= 1'b1;
            end
          end else if (i_dinZero) begin
            r_state <= SEARCH;
          end else begin
            r_match <= '0;
          end
        end
        LOCKED: begin
          if (i_dinMatch) begin
            r_miss <= '0;
          end else begin
            r_miss <= w_missInc;
            if (w_missInc == UNLOCK_TARGET) begin
              r_state  <= SEARCH;
              r_locked <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_locked = r_locked;

`ifdef LFSR_CHK_PERIOD_EN
  assign o_unlock = i_en && (r_state == LOCKED) && !i_dinMatch && (w_missInc == UNLOCK_TARGET);
`endif

endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: locks onto an LFSR state stream, predicts each word and counts mismatches.
// Optional macro LFSR_CHK_PERIOD_EN adds o_period_ok, a full-period check while LOCKED.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS,
  parameter int               LOCK_CNT    = 3,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               ERR_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_din,
  input  logic                 i_clr,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic                 o_period_ok
`endif
);

  lfsr_state_e          w_state;
  logic                 w_locked;
  logic [WIDTH-1:0]     r_exp;
  logic [WIDTH-1:0]     w_nextDin;
  logic [WIDTH-1:0]     w_nextExp;
  logic                 w_dinZero;
  logic                 w_dinMatch;
  logic                 w_lockedMiss;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_errCnt;

  assign w_nextDin    = WIDTH'(lfsr_next(LFSR_MAX_W'(i_din), LFSR_MAX_W'(TAPS)));
  assign w_nextExp    = WIDTH'(lfsr_next(LFSR_MAX_W'(r_exp), LFSR_MAX_W'(TAPS)));
  assign w_dinZero    = (i_din == '0);
  assign w_dinMatch   = (i_din == r_exp);
  assign w_lockedMiss = i_en && (w_state == LOCKED) && !w_dinMatch;

`ifdef LFSR_CHK_PERIOD_EN
  logic w_unlock;
`endif

  lfsr_seq_checker_fsm #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_ERRS(UNLOCK_ERRS)
  ) u_fsm (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (i_en),
    .i_dinZero (w_dinZero),
    .i_dinMatch(w_dinMatch),
    .o_state   (w_state),
    .o_locked  (w_locked)
`ifdef LFSR_CHK_PERIOD_EN
    ,
    .o_unlock  (w_unlock)
`endif
  );

  // While acquiring, the prediction follows din; once locked it flywheels on itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp <= '0;
    end else if (i_en) begin
      case (w_state)
        SEARCH, VERIFY: begin
          if (!w_dinZero) r_exp <= w_nextDin;
        end
        LOCKED:  r_exp <= w_nextExp;
        default: r_exp <= r_exp;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err    <= 1'b0;
      r_errCnt <= '0;
    end else begin
      r_err <= w_lockedMiss;
      if (i_clr) begin
        r_errCnt <= '0;
      end else if (w_lockedMiss && (r_errCnt != '1)) begin
        r_errCnt <= r_errCnt + ERR_CNT_W'(1);
      end
    end
  end

  assign o_locked  = w_locked;
  assign o_err     = r_err;
  assign o_err_cnt = r_errCnt;

`ifdef LFSR_CHK_PERIOD_EN
  logic [WIDTH-1:0] r_entryWord;
  logic [WIDTH-1:0] r_periodCnt;
  logic [WIDTH-1:0] w_periodCntInc;
  logic             r_periodOk;

  assign w_periodCntInc = r_periodCnt + WIDTH'(1);

  // The last pre-lock sample is the entry word; it recurs after exactly 2**WIDTH-1 LOCKED samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entryWord <= '0;
      r_periodCnt <= '0;
      r_periodOk  <= 1'b0;
    end else if (i_en) begin
      if (w_state != LOCKED) begin
        r_entryWord <= i_din;
        r_periodCnt <= '0;
        r_periodOk  <= 1'b0;
      end else if (w_unlock) begin
        r_periodCnt <= '0;
        r_periodOk  <= 1'b0;
      end else if (i_din == r_entryWord) begin
        r_periodOk  <= (w_periodCntInc == '1);
        r_periodCnt <= '0;
      end else begin
        r_periodCnt <= w_periodCntInc;
      end
    end
  end

  assign o_period_ok = r_periodOk;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed bench for lfsr_seq_checker (WIDTH=4, TAPS=4'b1100).
// Define LFSR_CHK_PERIOD_EN for both bench and RTL to also exercise o_period_ok.
`timescale 1ns/1ps
module tb_lfsr_seq_checker;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       clr    = 1'b0;
  logic [3:0] din    = 4'b0000;
  logic       locked;
  logic       err;
  logic [7:0] errCnt;
`ifdef LFSR_CHK_PERIOD_EN
  logic       periodOk;
`endif

  int checkCount = 0;
  int errCount   = 0;
  int pos;

  // Period-15 sequence starting at 0001, computed by hand from fb = cur[3]^cur[2].
  logic [3:0] seqTable [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clk = ~clk;

  lfsr_seq_checker dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_din      (din),
    .i_clr      (clr),
    .o_locked   (locked),
    .o_err      (err),
    .o_err_cnt  (errCnt)
`ifdef LFSR_CHK_PERIOD_EN
    ,
    .o_period_ok(periodOk)
`endif
  );

  function automatic logic [3:0] seqWord(input int idx);
    return seqTable[idx % 15];
  endfunction

  task automatic applyStimulus(input logic e, input logic [3:0] d, input logic c);
    @(negedge clk);
    en  = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (locked !== 1'b0) begin errCount++; $display("[TB] FAIL reset_locked: got=%0b want=0", locked); end
    checkCount++;
    if (err !== 1'b0) begin errCount++; $display("[TB] FAIL reset_err: got=%0b want=0", err); end
    checkCount++;
    if (errCnt !== 8'd0) begin errCount++; $display("[TB] FAIL reset_errcnt: got=%0d want=0", errCnt); end
`ifdef LFSR_CHK_PERIOD_EN
    checkCount++;
    if (periodOk !== 1'b0) begin errCount++; $display("[TB] FAIL reset_periodok: got=%0b want=0", periodOk); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    pos = 14;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
      checkCount++;
      if (err !== 1'b0) begin errCount++; $display("[TB] FAIL clean_err sample %0d: got=%0b want=0", i, err); end
      if (i == 3) begin
        checkCount++;
        if (locked !== 1'b0) begin errCount++; $display("[TB] FAIL clean_notyet: got=%0b want=0", locked); end
      end
      if (i == 4) begin
        checkCount++;
        if (locked !== 1'b1) begin errCount++; $display("[TB] FAIL clean_lock4: got=%0b want=1", locked); end
      end
    end
    checkCount++;
    if (errCnt !== 8'd0) begin errCount++; $display("[TB] FAIL clean_errcnt: got=%0d want=0", errCnt); end
  endtask

  task automatic test_single_error();
    while (pos != 4) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
    end
    applyStimulus(1'b1, 4'b0000, 1'b0);
    pos = 5;
    checkCount++;
    if (err !== 1'b1) begin errCount++; $display("[TB] FAIL single_err: got=%0b want=1", err); end
    checkCount++;
    if (errCnt !== 8'd1) begin errCount++; $display("[TB] FAIL single_errcnt: got=%0d want=1", errCnt); end
    checkCount++;
    if (locked !== 1'b1) begin errCount++; $display("[TB] FAIL single_locked: got=%0b want=1", locked); end
    applyStimulus(1'b1, seqWord(pos), 1'b0);
    pos = (pos + 1) % 15;
    checkCount++;
    if (err !== 1'b0) begin errCount++; $display("[TB] FAIL single_recover_err: got=%0b want=0", err); end
    checkCount++;
    if (errCnt !== 8'd1) begin errCount++; $display("[TB] FAIL single_recover_cnt: got=%0d want=1", errCnt); end
  endtask

  task automatic test_unlock_relock();
    applyStimulus(1'b1, seqWord(pos), 1'b1);
    pos = (pos + 1) % 15;
    checkCount++;
    if (errCnt !== 8'd0) begin errCount++; $display("[TB] FAIL unlock_clr: got=%0d want=0", errCnt); end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, seqWord(pos) ^ 4'b0101, 1'b0);
      pos = (pos + 1) % 15;
      checkCount++;
      if (err !== 1'b1) begin errCount++; $display("[TB] FAIL unlock_err %0d: got=%0b want=1", k, err); end
      checkCount++;
      if (errCnt !== 8'(k)) begin errCount++; $display("[TB] FAIL unlock_cnt %0d: got=%0d want=%0d", k, errCnt, k); end
      checkCount++;
      if (locked !== (k < 4)) begin errCount++; $display("[TB] FAIL unlock_locked %0d: got=%0b want=%0b", k, locked, (k < 4)); end
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
      checkCount++;
      if (locked !== (k == 4)) begin errCount++; $display("[TB] FAIL relock %0d: got=%0b want=%0b", k, locked, (k == 4)); end
      checkCount++;
      if (err !== 1'b0) begin errCount++; $display("[TB] FAIL relock_err %0d: got=%0b want=0", k, err); end
    end
  endtask

  task automatic test_zero_hold();
    doReset();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0);
      checkCount++;
      if (locked !== 1'b0 || err !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL zero_hold %0d: locked=%0b err=%0b want 0/0", i, locked, err);
      end
    end
    checkCount++;
    if (errCnt !== 8'd0) begin errCount++; $display("[TB] FAIL zero_errcnt: got=%0d want=0", errCnt); end
  endtask

  task automatic test_saturation();
    int model;
    pos = 0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
    end
    checkCount++;
    if (locked !== 1'b1) begin errCount++; $display("[TB] FAIL sat_lock: got=%0b want=1", locked); end
    model = 0;
    for (int g = 0; g < 86; g++) begin
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b1, seqWord(pos) ^ 4'b0101, 1'b0);
        pos = (pos + 1) % 15;
        if (model < 255) model++;
      end
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
      checkCount++;
      if (errCnt !== 8'(model) || locked !== 1'b1) begin
        errCount++;
        $display("[TB] FAIL sat_group %0d: errcnt=%0d locked=%0b want %0d/1", g, errCnt, locked, model);
      end
    end
    checkCount++;
    if (errCnt !== 8'd255) begin errCount++; $display("[TB] FAIL sat_hold: got=%0d want=255", errCnt); end
    applyStimulus(1'b1, seqWord(pos) ^ 4'b0101, 1'b1);
    pos = (pos + 1) % 15;
    checkCount++;
    if (errCnt !== 8'd0) begin errCount++; $display("[TB] FAIL clr_wins: got=%0d want=0", errCnt); end
    checkCount++;
    if (err !== 1'b1) begin errCount++; $display("[TB] FAIL clr_err_pulse: got=%0b want=1", err); end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, seqWord(pos) ^ 4'b0101, 1'b0);
    pos = (pos + 1) % 15;
    checkCount++;
    if (locked !== 1'b1 || err !== 1'b1 || errCnt !== 8'd1) begin
      errCount++;
      $display("[TB] FAIL pre_async: locked=%0b err=%0b errcnt=%0d want 1/1/1", locked, err, errCnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (locked !== 1'b0 || err !== 1'b0 || errCnt !== 8'd0) begin
      errCount++;
      $display("[TB] FAIL async_reset: locked=%0b err=%0b errcnt=%0d want 0/0/0", locked, err, errCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef LFSR_CHK_PERIOD_EN
  task automatic test_period();
    doReset();
    pos = 0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
    end
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b1, seqWord(pos), 1'b0);
      pos = (pos + 1) % 15;
      checkCount++;
      if (periodOk !== (k == 15)) begin
        errCount++;
        $display("[TB] FAIL period %0d: got=%0b want=%0b", k, periodOk, (k == 15));
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] starting lfsr_seq_checker directed tests");
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_zero_hold();
    test_saturation();
    test_async_reset();
`ifdef LFSR_CHK_PERIOD_EN
    test_period();
`endif
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
